// File: rtl/lockstep_pkg.sv
// Shared definitions for the lockstep checker: FSM encoding and compare modes.
package lockstep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2
   } state_e;

   // Compare modes: cycle-exact lockstep, or skew-tolerant transaction compare.
   localparam int MODE_CYCLE = 0;
   localparam int MODE_TXN   = 1;

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/lockstep_fifo.sv
// Skew FIFO for one side of one channel. Pointers carry one extra wrap bit so
// full and empty are distinguishable; the low bits index storage modulo DEPTH.
module lockstep_fifo
#(
   parameter int W     = 70,
   parameter int DEPTH = 8
)(
   input  logic         clock,
   input  logic         resetn,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [PW:0]  r_wr_ptr;
   logic [PW:0]  r_rd_ptr;
   logic         w_do_push;
   logic         w_do_pop;

   // Status flags and accepted push/pop; a pop in the same cycle frees room for a push into a full FIFO.
   always_comb begin
      o_empty   = (r_wr_ptr == r_rd_ptr);
      o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                  (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
      w_do_pop  = i_pop && !o_empty && !i_flush;
      w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;
      o_data    = r_mem[r_rd_ptr[PW-1:0]];
   end

   // Pointer update; flush returns both pointers to the empty position.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because the pointers define validity.
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
   end

endmodule

// File: rtl/lockstep_checker.sv
// Lockstep checker: compares a DUT bus stream against a golden-model stream,
// either cycle-exact (MODE_CYCLE) or through per-side skew FIFOs (MODE_TXN),
// and freezes the first failure for inspection.
//
// Handshake: dut_valid[c]/gold_valid[c] are one-cycle beat strobes qualifying
// the matching payload slice in the same cycle; there is no back-pressure, so
// every strobe seen in RUN is consumed (compared or queued) at that edge.
module lockstep_checker
   import lockstep_pkg::*;
#(
   parameter int CH    = 1,
   parameter int W     = 70,
   parameter int DEPTH = 8,
   parameter int MODE  = MODE_CYCLE
)(
   input  logic                                 clock,
   input  logic                                 resetn,
   input  logic                                 enable,
   input  logic                                 clear,
   input  logic [CH-1:0]                        dut_valid,
   input  logic [CH*W-1:0]                      dut_data,
   input  logic [CH-1:0]                        gold_valid,
   input  logic [CH*W-1:0]                      gold_data,
   output logic                                 mismatch,
   output logic                                 overflow,
   output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] fail_ch,
   output logic [W-1:0]                         fail_dut,
   output logic [W-1:0]                         fail_gold,
   output logic [31:0]                          fail_cycle,
   output logic [31:0]                          beat_count,
   output logic [1:0]                           state
);

   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   state_e          r_state;
   state_e          w_next;
   logic            w_run;

   logic            r_mismatch;
   logic            r_overflow;
   logic [CHW-1:0]  r_fail_ch;
   logic [W-1:0]    r_fail_dut;
   logic [W-1:0]    r_fail_gold;
   logic [31:0]     r_fail_cycle;
   logic [31:0]     r_cycle;
   logic [31:0]     r_beat_cnt;

   logic [CH-1:0]   w_push_d;
   logic [CH-1:0]   w_push_g;
   logic [CH-1:0]   w_pop;
   logic [CH-1:0]   w_full_d;
   logic [CH-1:0]   w_full_g;
   logic [CH-1:0]   w_empty_d;
   logic [CH-1:0]   w_empty_g;
   logic [W-1:0]    w_head_d [CH];
   logic [W-1:0]    w_head_g [CH];

   logic [CH-1:0]   w_ch_fail;
   logic [CH-1:0]   w_ch_ovf;
   logic [CH-1:0]   w_ch_ok;
   logic [W-1:0]    w_cap_d [CH];
   logic [W-1:0]    w_cap_g [CH];
   logic            w_any_fail;
   logic            w_any_ovf;
   logic [CHW-1:0]  w_sel_ch;
   logic [W-1:0]    w_sel_d;
   logic [W-1:0]    w_sel_g;
   logic [32:0]     w_beat_sum;

   // Skew FIFOs exist only in transaction mode; cycle mode sees permanently empty queues.
   for (genvar c = 0; c < CH; c++) begin : g_ch
      if (MODE == MODE_TXN) begin : g_txn
         lockstep_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_dut (
            .clock   (clock),
            .resetn  (resetn),
            .i_flush (clear),
            .i_push  (w_push_d[c]),
            .i_pop   (w_pop[c]),
            .i_data  (dut_data[c*W +: W]),
            .o_data  (w_head_d[c]),
            .o_full  (w_full_d[c]),
            .o_empty (w_empty_d[c])
         );
         lockstep_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_gold (
            .clock   (clock),
            .resetn  (resetn),
            .i_flush (clear),
            .i_push  (w_push_g[c]),
            .i_pop   (w_pop[c]),
            .i_data  (gold_data[c*W +: W]),
            .o_data  (w_head_g[c]),
            .o_full  (w_full_g[c]),
            .o_empty (w_empty_g[c])
         );
      end else begin : g_cyc
         assign w_head_d[c]  = '0;
         assign w_head_g[c]  = '0;
         assign w_full_d[c]  = 1'b0;
         assign w_full_g[c]  = 1'b0;
         assign w_empty_d[c] = 1'b1;
         assign w_empty_g[c] = 1'b1;
      end
   end

   // Per-channel compare, queue control and selection of the lowest failing channel.
   always_comb begin
      w_push_d   = '0;
      w_push_g   = '0;
      w_pop      = '0;
      w_ch_fail  = '0;
      w_ch_ovf   = '0;
      w_ch_ok    = '0;
      w_sel_ch   = '0;
      w_sel_d    = '0;
      w_sel_g    = '0;
      w_beat_sum = {1'b0, r_beat_cnt};
      for (int c = 0; c < CH; c++) begin
         w_cap_d[c] = dut_data[c*W +: W];
         w_cap_g[c] = gold_data[c*W +: W];
         if (MODE == MODE_TXN) begin
            w_push_d[c]  = w_run && dut_valid[c];
            w_push_g[c]  = w_run && gold_valid[c];
            w_pop[c]     = w_run && !w_empty_d[c] && !w_empty_g[c];
            w_ch_ovf[c]  = (w_push_d[c] && w_full_d[c] && !w_pop[c]) ||
                           (w_push_g[c] && w_full_g[c] && !w_pop[c]);
            w_ch_ok[c]   = w_pop[c] && (w_head_d[c] == w_head_g[c]);
            if (w_pop[c] && (w_head_d[c] != w_head_g[c])) begin
               w_ch_fail[c] = 1'b1;
               w_cap_d[c]   = w_head_d[c];
               w_cap_g[c]   = w_head_g[c];
            end else begin
               w_ch_fail[c] = w_ch_ovf[c];
            end
         end else begin
            w_ch_ok[c]   = w_run && dut_valid[c] && gold_valid[c] &&
                           (dut_data[c*W +: W] == gold_data[c*W +: W]);
            w_ch_fail[c] = w_run && ((dut_valid[c] != gold_valid[c]) ||
                           (dut_valid[c] && gold_valid[c] &&
                            (dut_data[c*W +: W] != gold_data[c*W +: W])));
         end
         w_beat_sum = w_beat_sum + 33'(w_ch_ok[c]);
      end
      for (int c = CH - 1; c >= 0; c--) begin
         if (w_ch_fail[c]) begin
            w_sel_ch = CHW'(c);
            w_sel_d  = w_cap_d[c];
            w_sel_g  = w_cap_g[c];
         end
      end
      w_any_fail = |w_ch_fail;
      w_any_ovf  = |w_ch_ovf;
   end

   // FSM state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // FSM next state; clear beats every other event, a failure beats enable dropping.
   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (enable) w_next = ST_RUN;
            ST_RUN: begin
               if (w_any_fail)   w_next = ST_FAIL;
               else if (!enable) w_next = ST_IDLE;
            end
            ST_FAIL: w_next = ST_FAIL;
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // FSM outputs: exposed state and the qualifier for compares/pushes/pops.
   always_comb begin
      state = r_state;
      w_run = (r_state == ST_RUN) && !clear;
   end

   // Counters, sticky flags and first-failure capture; only RUN cycles update them.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_mismatch   <= 1'b0;
         r_overflow   <= 1'b0;
         r_fail_ch    <= '0;
         r_fail_dut   <= '0;
         r_fail_gold  <= '0;
         r_fail_cycle <= '0;
         r_cycle      <= '0;
         r_beat_cnt   <= '0;
      end else if (clear) begin
         r_mismatch   <= 1'b0;
         r_overflow   <= 1'b0;
         r_fail_ch    <= '0;
         r_fail_dut   <= '0;
         r_fail_gold  <= '0;
         r_fail_cycle <= '0;
         r_cycle      <= '0;
         r_beat_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
         if (r_cycle != CNT_MAX) r_cycle <= r_cycle + 32'd1;
         r_beat_cnt <= w_beat_sum[32] ? CNT_MAX : w_beat_sum[31:0];
         if (w_any_fail) begin
            r_mismatch   <= 1'b1;
            r_overflow   <= w_any_ovf;
            r_fail_ch    <= w_sel_ch;
            r_fail_dut   <= w_sel_d;
            r_fail_gold  <= w_sel_g;
            r_fail_cycle <= r_cycle;
         end
      end
   end

   assign mismatch   = r_mismatch;
   assign overflow   = r_overflow;
   assign fail_ch    = r_fail_ch;
   assign fail_dut   = r_fail_dut;
   assign fail_gold  = r_fail_gold;
   assign fail_cycle = r_fail_cycle;
   assign beat_count = r_beat_cnt;

endmodule
